// File: rtl/rn_node_pkg.sv
// Shared definitions for the request node and its slave-node peer:
// transaction ID sizing, request/response payloads and a free-ID search helper.
package node_package;

  localparam int NUM_TXN = 8;
  localparam int ID_W    = $clog2(NUM_TXN);

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } OpType;

  typedef struct packed {
    OpType            opcode;
    logic [ID_W-1:0]  txn_id;
    logic [15:0]      addr;
  } ReqType;

  typedef struct packed {
    logic [ID_W-1:0]  txn_id;
    logic [31:0]      data;
  } DataType;

  typedef struct packed {
    logic             found;
    logic [ID_W-1:0]  id;
  } FreeSlot;

  // Lowest-numbered ID whose busy bit is clear; found=0 when all IDs are in flight.
  function automatic FreeSlot lowest_free(input logic [NUM_TXN-1:0] busy);
    FreeSlot slot;
    slot.found = 1'b0;
    slot.id    = '0;
    for (int i = NUM_TXN - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        slot.found = 1'b1;
        slot.id    = ID_W'(i);
      end
    end
    return slot;
  endfunction

endpackage

// File: rtl/rn_node_credit_fifo.sv
// Receive-side DATA FIFO together with the count of DATA credits granted to the
// slave node. A credit is granted whenever granted-but-unused credits plus
// occupied entries leave room, so the FIFO can never be overrun by a
// well-behaved peer.
module credit_fifo
  import node_package::*;
#(
  parameter int RX_DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  DataType push_data,
  input  logic    pop,
  output DataType pop_data,
  output logic    full,
  output logic    empty,
  output logic    grant,
  output logic    no_credit
);

  localparam int CNT_W = $clog2(RX_DEPTH + 1);
  localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(RX_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_C1  = (CNT_W + 1)'(RX_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RX_DEPTH - 1);

  DataType          mem_q [RX_DEPTH];
  logic [CNT_W-1:0] g_q, g_d, g_upd;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W:0]   committed;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             grant_q, grant_d;
  logic             push_ok, pop_ok;

  assign full     = (occ_q == DEPTH_C);
  assign empty    = (occ_q == '0);
  assign grant    = grant_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Accept/drop decision, occupancy and credit bookkeeping for this edge.
  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    pop_ok    = pop && !empty;
    no_credit = push && (g_q == '0);
    push_ok   = push && !no_credit && (!full || pop_ok);
    g_upd     = g_q - CNT_W'(push_ok);
    occ_d     = occ_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    committed = {1'b0, g_upd} + {1'b0, occ_d};
    grant_d   = (committed < DEPTH_C1);
    g_d       = g_upd + CNT_W'(grant_d);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
  end

  // Control state: counters, pointers and the registered credit grant.
  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q      <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      grant_q  <= 1'b0;
    end else begin
      g_q      <= g_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Payload storage written on every accepted beat.
  // NOTE: storage array is not reset; occupancy guards every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rn_node.sv
// Request node: issues READ requests against REQ link credits, tracks
// outstanding transaction IDs, drains DATA responses from the credit FIFO into
// registered completions, and flags protocol violations in a sticky error.
module rn_node
  import node_package::*;
#(
  parameter int TX_CRD_MAX  = 4,
  parameter int RX_DEPTH    = 4,
  parameter int ADDR_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             work,
  input  logic             pre_tx_req,
  output ReqType           tx_req,
  output logic             v_tx_req,
  output logic             pre_rx_data,
  input  DataType          rx_data,
  input  logic             v_rx_data,
  output logic             cmp_valid,
  output logic [ID_W-1:0]  cmp_id,
  output logic [31:0]      cmp_data,
  output logic             err
);

  localparam int CRD_W = $clog2(TX_CRD_MAX + 1);
  localparam logic [CRD_W-1:0] CRD_MAX_C = CRD_W'(TX_CRD_MAX);
  localparam logic [15:0]      STRIDE_C  = 16'(ADDR_STRIDE);

  logic [CRD_W-1:0]   crd_q, crd_d;
  logic [15:0]        addr_q, addr_d;
  logic [NUM_TXN-1:0] busy_q, busy_d;
  ReqType             tx_req_q, tx_req_d;
  logic               v_tx_req_q, v_tx_req_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic [ID_W-1:0]    cmp_id_q, cmp_id_d;
  logic [31:0]        cmp_data_q, cmp_data_d;
  logic               err_q, err_d;

  FreeSlot            slot;
  logic               issue, crd_overflow, rx_bad, stale_pop, cmp_ok;
  logic               fifo_full, fifo_empty, fifo_pop, fifo_grant, fifo_no_credit;
  DataType            fifo_head;

  // The FIFO drains one entry per cycle whenever it holds anything.
  assign fifo_pop = !fifo_empty;

  credit_fifo #(
    .RX_DEPTH (RX_DEPTH)
  ) u_credit_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (v_rx_data),
    .push_data (rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .grant     (fifo_grant),
    .no_credit (fifo_no_credit)
  );

  // Issue decision, credit accounting, ID table, completion and error next-state.
  always_comb begin
    slot         = lowest_free(busy_q);
    issue        = work && (crd_q != '0) && slot.found;
    crd_overflow = 1'b0;
    crd_d        = crd_q;
    case ({pre_tx_req, issue})
      2'b10: begin
        if (crd_q == CRD_MAX_C) crd_overflow = 1'b1;
        else                    crd_d = crd_q + 1'b1;
      end
      2'b01:   crd_d = crd_q - 1'b1;
      default: crd_d = crd_q;
    endcase

    addr_d     = addr_q;
    tx_req_d   = tx_req_q;
    v_tx_req_d = issue;
    if (issue) begin
      tx_req_d.opcode = READ;
      tx_req_d.txn_id = slot.id;
      tx_req_d.addr   = addr_q;
      addr_d          = addr_q + STRIDE_C;
    end

    // A popped beat completes only if its ID is still outstanding; this also
    // catches a duplicate response that arrived while the ID was busy.
    cmp_ok    = fifo_pop && busy_q[fifo_head.txn_id];
    stale_pop = fifo_pop && !busy_q[fifo_head.txn_id];
    rx_bad    = v_rx_data && !fifo_no_credit && !busy_q[rx_data.txn_id];

    busy_d = busy_q;
    if (cmp_ok) busy_d[fifo_head.txn_id] = 1'b0;
    if (issue)  busy_d[slot.id]          = 1'b1;

    cmp_valid_d = cmp_ok;
    cmp_id_d    = cmp_id_q;
    cmp_data_d  = cmp_data_q;
    if (cmp_ok) begin
      cmp_id_d   = fifo_head.txn_id;
      cmp_data_d = fifo_head.data;
    end

    err_d = err_q | crd_overflow | fifo_no_credit | rx_bad | stale_pop
          | (v_rx_data && fifo_full);
  end

  // Registered request, completion and bookkeeping state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crd_q       <= '0;
      addr_q      <= '0;
      busy_q      <= '0;
      tx_req_q    <= '0;
      v_tx_req_q  <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_id_q    <= '0;
      cmp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      crd_q       <= crd_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      tx_req_q    <= tx_req_d;
      v_tx_req_q  <= v_tx_req_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_id_q    <= cmp_id_d;
      cmp_data_q  <= cmp_data_d;
      err_q       <= err_d;
    end
  end

  assign tx_req      = tx_req_q;
  assign v_tx_req    = v_tx_req_q;
  assign pre_rx_data = fifo_grant;
  assign cmp_valid   = cmp_valid_q;
  assign cmp_id      = cmp_id_q;
  assign cmp_data    = cmp_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_rn_node.sv
// Directed bench for rn_node: a per-cycle vector table for issue and round
// trip, plus hand-written sequences for grant start-up, ID exhaustion,
// protocol errors, credit saturation and mid-operation reset.
module tb_rn_node;
  import node_package::*;

  logic            clk;
  logic            reset;
  logic            work;
  logic            pre_tx_req;
  ReqType          tx_req;
  logic            v_tx_req;
  logic            pre_rx_data;
  DataType         rx_data;
  logic            v_rx_data;
  logic            cmp_valid;
  logic [ID_W-1:0] cmp_id;
  logic [31:0]     cmp_data;
  logic            err;

  int tests;
  int failed;

  rn_node dut (
    .clk         (clk),
    .reset       (reset),
    .work        (work),
    .pre_tx_req  (pre_tx_req),
    .tx_req      (tx_req),
    .v_tx_req    (v_tx_req),
    .pre_rx_data (pre_rx_data),
    .rx_data     (rx_data),
    .v_rx_data   (v_rx_data),
    .cmp_valid   (cmp_valid),
    .cmp_id      (cmp_id),
    .cmp_data    (cmp_data),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        work;
    logic        pre;
    logic        vrx;
    logic [2:0]  rx_id;
    logic [31:0] rx_dat;
    logic        e_vtx;
    logic [2:0]  e_id;
    logic [15:0] e_addr;
    logic        e_pre_rx;
    logic        e_cmp;
    logic [2:0]  e_cmp_id;
    logic [31:0] e_cmp_data;
    logic        e_err;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    work       = 1'b0;
    pre_tx_req = 1'b0;
    v_rx_data  = 1'b0;
    rx_data    = '0;
    #1;
    check("rst v_tx_req",    32'(v_tx_req),    32'd0);
    check("rst tx_req",      32'(tx_req),      32'd0);
    check("rst pre_rx_data", 32'(pre_rx_data), 32'd0);
    check("rst cmp_valid",   32'(cmp_valid),   32'd0);
    check("rst err",         32'(err),         32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    // Issue with credits, then a round trip and ID 0 reuse.
    //            work pre vrx id  rx_dat        vtx id addr      prx cmp cid data          err
    vecs[0]  = '{1'b0,1'b1,1'b0,3'd0,32'h0,        1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,32'h0,        1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,3'd0,32'h0,        1'b0,3'd0,16'h0000,1'b1,1'b0,3'd0,32'h0,        1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,3'd0,32'h0,        1'b1,3'd0,16'h0000,1'b1,1'b0,3'd0,32'h0,        1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b0,3'd0,32'h0,        1'b1,3'd1,16'h0004,1'b1,1'b0,3'd0,32'h0,        1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b0,3'd0,32'h0,        1'b0,3'd1,16'h0004,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b0,3'd0,32'h0,        1'b0,3'd1,16'h0004,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b0,3'd0,32'h0,        1'b0,3'd1,16'h0004,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,3'd0,32'h0,        1'b0,3'd1,16'h0004,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[8]  = '{1'b1,1'b1,1'b0,3'd0,32'h0,        1'b0,3'd1,16'h0004,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,3'd0,32'h0,        1'b1,3'd2,16'h0008,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1,3'd0,32'hA5A5A5A5, 1'b0,3'd2,16'h0008,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,3'd0,32'h0,        1'b0,3'd2,16'h0008,1'b1,1'b1,3'd0,32'hA5A5A5A5, 1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,3'd0,32'h0,        1'b0,3'd2,16'h0008,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[13] = '{1'b1,1'b1,1'b0,3'd0,32'h0,        1'b0,3'd2,16'h0008,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[14] = '{1'b1,1'b0,1'b0,3'd0,32'h0,        1'b1,3'd0,16'h000C,1'b0,1'b0,3'd0,32'h0,        1'b0};
    vecs[15] = '{1'b0,1'b0,1'b0,3'd0,32'h0,        1'b0,3'd0,16'h000C,1'b0,1'b0,3'd0,32'h0,        1'b0};

    // Reset then idle: exactly four grant cycles, no requests.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("idle c%0d pre_rx_data", c), 32'(pre_rx_data), (c < 4) ? 32'd1 : 32'd0);
      check($sformatf("idle c%0d v_tx_req", c),    32'(v_tx_req),    32'd0);
    end

    // Table-driven issue / round trip.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      work         = vecs[i].work;
      pre_tx_req   = vecs[i].pre;
      v_rx_data    = vecs[i].vrx;
      rx_data.txn_id = vecs[i].rx_id;
      rx_data.data   = vecs[i].rx_dat;
      @(negedge clk);
      check($sformatf("row%0d v_tx_req", i),    32'(v_tx_req),       32'(vecs[i].e_vtx));
      check($sformatf("row%0d opcode", i),      32'(tx_req.opcode),  32'(READ));
      check($sformatf("row%0d txn_id", i),      32'(tx_req.txn_id),  32'(vecs[i].e_id));
      check($sformatf("row%0d addr", i),        32'(tx_req.addr),    32'(vecs[i].e_addr));
      check($sformatf("row%0d pre_rx_data", i), 32'(pre_rx_data),    32'(vecs[i].e_pre_rx));
      check($sformatf("row%0d cmp_valid", i),   32'(cmp_valid),      32'(vecs[i].e_cmp));
      check($sformatf("row%0d err", i),         32'(err),            32'(vecs[i].e_err));
      if (vecs[i].e_cmp) begin
        check($sformatf("row%0d cmp_id", i),   32'(cmp_id),   32'(vecs[i].e_cmp_id));
        check($sformatf("row%0d cmp_data", i), cmp_data,      vecs[i].e_cmp_data);
      end
    end

    // ID exhaustion: eight credits trickled in, eight requests, then stall.
    begin
      int n;
      logic [2:0]  ids   [8];
      logic [15:0] addrs [8];
      n = 0;
      do_reset();
      work = 1'b1;
      pre_tx_req = 1'b1;
      for (int c = 0; c < 14; c++) begin
        if (c == 8) pre_tx_req = 1'b0;
        @(negedge clk);
        if (v_tx_req) begin
          if (n < 8) begin
            ids[n]   = tx_req.txn_id;
            addrs[n] = tx_req.addr;
          end
          n++;
        end
      end
      check("exhaust count", 32'(n), 32'd8);
      for (int k = 0; k < 8; k++) begin
        check($sformatf("exhaust id%0d", k),   32'(ids[k]),   32'(k));
        check($sformatf("exhaust addr%0d", k), 32'(addrs[k]), 32'(k * 4));
      end
      pre_tx_req = 1'b1;
      @(negedge clk);
      pre_tx_req = 1'b0;
      n = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (v_tx_req) n++;
      end
      check("stall no issue", 32'(n), 32'd0);
      v_rx_data      = 1'b1;
      rx_data.txn_id = 3'd3;
      rx_data.data   = 32'h3333_3333;
      @(negedge clk);
      v_rx_data = 1'b0;
      check("id3 push no cmp", 32'(cmp_valid), 32'd0);
      @(negedge clk);
      check("id3 cmp_valid", 32'(cmp_valid), 32'd1);
      check("id3 cmp_id",    32'(cmp_id),    32'd3);
      check("id3 cmp_data",  cmp_data,       32'h3333_3333);
      check("id3 no issue yet", 32'(v_tx_req), 32'd0);
      @(negedge clk);
      check("reuse v_tx_req", 32'(v_tx_req),      32'd1);
      check("reuse txn_id",   32'(tx_req.txn_id), 32'd3);
      check("reuse addr",     32'(tx_req.addr),   32'h20);
      check("reuse err",      32'(err),           32'd0);
    end

    // Protocol error: response before any credit was granted.
    do_reset();
    v_rx_data      = 1'b1;
    rx_data.txn_id = 3'd0;
    rx_data.data   = 32'h1;
    @(negedge clk);
    v_rx_data = 1'b0;
    check("nocrd err", 32'(err), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("nocrd c%0d cmp_valid", c), 32'(cmp_valid), 32'd0);
    end

    // Protocol error: response for an ID that is not outstanding.
    do_reset();
    repeat (5) @(negedge clk);
    check("badid pre err", 32'(err), 32'd0);
    v_rx_data      = 1'b1;
    rx_data.txn_id = 3'd5;
    rx_data.data   = 32'h55;
    @(negedge clk);
    v_rx_data = 1'b0;
    check("badid err", 32'(err), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("badid c%0d cmp_valid", c), 32'(cmp_valid), 32'd0);
    end

    // REQ credit saturation: fifth credit with none consumed is an error.
    do_reset();
    pre_tx_req = 1'b1;
    repeat (4) @(negedge clk);
    check("sat at max err", 32'(err), 32'd0);
    @(negedge clk);
    pre_tx_req = 1'b0;
    check("sat overflow err", 32'(err), 32'd1);

    // Mid-operation reset with three requests outstanding.
    do_reset();
    work = 1'b1;
    pre_tx_req = 1'b1;
    repeat (3) @(negedge clk);
    pre_tx_req = 1'b0;
    @(negedge clk);
    work = 1'b0;
    check("mid pre v_tx_req", 32'(v_tx_req),      32'd1);
    check("mid pre txn_id",   32'(tx_req.txn_id), 32'd2);
    check("mid pre addr",     32'(tx_req.addr),   32'h8);
    check("mid pre pre_rx",   32'(pre_rx_data),   32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid rst v_tx_req", 32'(v_tx_req),    32'd0);
    check("mid rst tx_req",   32'(tx_req),      32'd0);
    check("mid rst pre_rx",   32'(pre_rx_data), 32'd0);
    check("mid rst cmp",      32'(cmp_valid),   32'd0);
    check("mid rst err",      32'(err),         32'd0);
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b1;
    work       = 1'b1;
    pre_tx_req = 1'b1;
    begin
      int grants;
      int first_id;
      int first_addr;
      grants     = 0;
      first_id   = -1;
      first_addr = -1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        pre_tx_req = 1'b0;
        if (pre_rx_data) grants++;
        if (v_tx_req && first_id < 0) begin
          first_id   = int'(tx_req.txn_id);
          first_addr = int'(tx_req.addr);
        end
      end
      check("after rst grants",     32'(grants),     32'd4);
      check("after rst first id",   32'(first_id),   32'd0);
      check("after rst first addr", 32'(first_addr), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
